// File: rtl/engine_sample_bridge.sv
`default_nettype none
// ============================================================================
// Module   : engine_sample_bridge
// Purpose  : Moves I2S samples into dsp_engine (rounded/saturated) and returns
//            processed samples, left-aligned, to the I2S transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module engine_sample_bridge #(
    parameter int IN_WIDTH       = 24,
    parameter int DATA_WIDTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   rx_sample,
    input  logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] engine_in_sample,
    output logic                  engine_sample_ready,
    input  logic                  engine_ready,
    input  logic [DATA_WIDTH-1:0] engine_out_sample,
    output logic [IN_WIDTH-1:0]   tx_sample,
    output logic                  tx_valid,
    output logic                  busy,
    output logic [15:0]           overrun_count,
    output logic [15:0]           timeout_count
);

    localparam int                    C_SH       = IN_WIDTH - DATA_WIDTH;
    localparam int                    C_TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_TW-1:0]       C_TIMER_LAST = C_TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IN_WIDTH:0]     C_HALF     = (IN_WIDTH + 1)'(1) << (C_SH - 1);
    localparam logic [DATA_WIDTH-1:0] C_MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [15:0]           C_CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_WAIT_ACCEPT = 2'd1,
        S_WAIT_DONE   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_sync_prev;
    logic [C_TW-1:0]         r_timer;
    logic [DATA_WIDTH-1:0]   r_in_sample;
    logic                    r_sample_ready;
    logic [IN_WIDTH-1:0]     r_tx_sample;
    logic                    r_tx_valid;
    logic [15:0]             r_overrun_count;
    logic [15:0]             r_timeout_count;

    logic                    w_rx_event;
    logic                    w_overrun;
    logic [IN_WIDTH:0]       w_rounded;
    logic                    w_sat;
    logic [DATA_WIDTH-1:0]   w_converted;
    logic                    w_timer_last;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_timeout;
    logic                    w_timer_clear;

    // rx_valid crosses from the bclk domain; only the synchronised level is used.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], rx_valid};
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rx_event = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_overrun  = w_rx_event & (r_state != S_IDLE);

    // Round half up in one extra bit; only positive values can carry into the sign.
    assign w_rounded   = {rx_sample[IN_WIDTH-1], rx_sample} + C_HALF;
    assign w_sat       = ~w_rounded[IN_WIDTH] & w_rounded[IN_WIDTH-1];
    assign w_converted = w_sat ? C_MAX_POS : w_rounded[IN_WIDTH-1:C_SH];

    assign w_timer_last = (r_timer == C_TIMER_LAST);

    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_done        = 1'b0;
        w_timeout     = 1'b0;
        w_timer_clear = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rx_event) begin
                    w_accept      = 1'b1;
                    w_timer_clear = 1'b1;
                    w_state_next  = S_WAIT_ACCEPT;
                end
            end
            // Engine ready is unknown before its first sample, so wait for a low level.
            S_WAIT_ACCEPT: begin
                if (!engine_ready) begin
                    w_timer_clear = 1'b1;
                    w_state_next  = S_WAIT_DONE;
                end else if (w_timer_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (engine_ready) begin
                    w_done       = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_timer_last) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_timer_clear || (w_state_next == S_IDLE)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_sample     <= '0;
            r_sample_ready  <= 1'b0;
            r_tx_sample     <= '0;
            r_tx_valid      <= 1'b0;
            r_overrun_count <= '0;
            r_timeout_count <= '0;
        end else begin
            r_sample_ready <= w_accept;
            r_tx_valid     <= w_done;
            if (w_accept) begin
                r_in_sample <= w_converted;
            end
            if (w_done) begin
                r_tx_sample <= {engine_out_sample, {C_SH{1'b0}}};
            end
            if (w_overrun && (r_overrun_count != C_CNT_MAX)) begin
                r_overrun_count <= r_overrun_count + 16'd1;
            end
            if (w_timeout && (r_timeout_count != C_CNT_MAX)) begin
                r_timeout_count <= r_timeout_count + 16'd1;
            end
        end
    end

    assign engine_in_sample    = r_in_sample;
    assign engine_sample_ready = r_sample_ready;
    assign tx_sample           = r_tx_sample;
    assign tx_valid            = r_tx_valid;
    assign busy                = (r_state != S_IDLE);
    assign overrun_count       = r_overrun_count;
    assign timeout_count       = r_timeout_count;

endmodule
`default_nettype wire

// File: tb/tb_engine_sample_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_engine_sample_bridge
// Purpose  : Scoreboard bench for engine_sample_bridge with a behavioural engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_engine_sample_bridge;

    localparam int TIMEOUT = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] rx_sample = '0;
    logic        rx_valid = 1'b0;
    logic [15:0] engine_in_sample;
    logic        engine_sample_ready;
    logic        eng_ready = 1'b1;
    logic [15:0] eng_out = '0;
    logic [23:0] tx_sample;
    logic        tx_valid;
    logic        busy;
    logic [15:0] overrun_count;
    logic [15:0] timeout_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_pulse = 0;
    int n_tx = 0;
    int last_pulse_cyc = 0;

    logic [15:0] exp_in_q[$];
    logic [23:0] exp_tx_q[$];

    bit          eng_active = 1'b0;
    bit          eng_stuck = 1'b0;
    int          eng_hold = 3;
    int          eng_cnt = 0;
    logic [15:0] eng_mask = '0;

    engine_sample_bridge #(
        .IN_WIDTH(24), .DATA_WIDTH(16), .SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .rx_sample(rx_sample), .rx_valid(rx_valid),
        .engine_in_sample(engine_in_sample), .engine_sample_ready(engine_sample_ready),
        .engine_ready(eng_ready), .engine_out_sample(eng_out),
        .tx_sample(tx_sample), .tx_valid(tx_valid), .busy(busy),
        .overrun_count(overrun_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Behavioural engine: drops ready for eng_hold cycles after each request.
    always @(posedge clk) begin
        if (reset) begin
            eng_active <= 1'b0;
            eng_ready  <= 1'b1;
        end else if (eng_stuck) begin
            eng_ready <= 1'b1;
        end else if (engine_sample_ready && !eng_active) begin
            eng_active <= 1'b1;
            eng_ready  <= 1'b0;
            eng_cnt    <= eng_hold;
            eng_out    <= engine_in_sample ^ eng_mask;
        end else if (eng_active) begin
            if (eng_cnt <= 1) begin
                eng_ready  <= 1'b1;
                eng_active <= 1'b0;
            end else begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    function automatic logic [15:0] ref_convert(input logic [23:0] s);
        int v;
        int r;
        v = int'($signed(s));
        r = (v + 128) >>> 8;
        if (r > 32767) r = 32767;
        return 16'(r);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output pulse.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (engine_sample_ready === 1'b1) begin
                n_pulse++;
                last_pulse_cyc = cyc;
                if (exp_in_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL in_sample: unexpected sample_ready, value 0x%0h", engine_in_sample);
                end else begin
                    chk("in_sample", 32'(engine_in_sample), 32'(exp_in_q.pop_front()));
                end
            end
            if (tx_valid === 1'b1) begin
                n_tx++;
                if (exp_tx_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_sample: unexpected tx_valid, value 0x%0h", tx_sample);
                end else begin
                    chk("tx_sample", 32'(tx_sample), 32'(exp_tx_q.pop_front()));
                end
            end
        end
    end

    task automatic drive_sample(input logic [23:0] s);
        #($urandom_range(1, 9));
        rx_sample = s;
        rx_valid  = 1'b1;
        repeat ($urandom_range(4, 7)) @(posedge clk);
        #($urandom_range(1, 9));
        rx_valid = 1'b0;
        repeat ($urandom_range(3, 6)) @(posedge clk);
    endtask

    task automatic issue(input logic [23:0] s, input bit accept, input bit complete);
        if (accept) exp_in_q.push_back(ref_convert(s));
        if (complete) exp_tx_q.push_back({ref_convert(s) ^ eng_mask, 8'h00});
        drive_sample(s);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy !== 1'b0 || eng_active) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(busy), 32'(0));
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_sample"}, 32'(engine_in_sample), 0);
        chk({tag, "_ready"}, 32'(engine_sample_ready), 0);
        chk({tag, "_tx_sample"}, 32'(tx_sample), 0);
        chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_overrun"}, 32'(overrun_count), 0);
        chk({tag, "_timeout"}, 32'(timeout_count), 0);
    endtask

    initial begin
        int p0;
        int t0;
        logic [23:0] s;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Rounding with echo engine
        eng_hold = 3;
        issue(24'h123480, 1'b1, 1'b1);
        wait_idle("idle_round");
        chk("round_hold_in", 32'(engine_in_sample), 32'(ref_convert(24'h123480)));
        chk("round_hold_tx", 32'(tx_sample), 32'({ref_convert(24'h123480), 8'h00}));

        // Saturation and negative boundaries, then a few random values with a transforming engine
        issue(24'h7FFFC0, 1'b1, 1'b1); wait_idle("idle_sat");
        issue(24'h800000, 1'b1, 1'b1); wait_idle("idle_neg");
        issue(24'hFFFF7F, 1'b1, 1'b1); wait_idle("idle_negr");
        issue(24'h7FFF7F, 1'b1, 1'b1); wait_idle("idle_edge");
        eng_mask = 16'h3C5A;
        for (int i = 0; i < 8; i++) begin
            eng_hold = $urandom_range(1, 4);
            issue(24'($urandom), 1'b1, 1'b1);
            wait_idle("idle_rand_mask");
        end
        eng_mask = '0;

        // Overrun: second event lands while the engine is still working
        eng_hold = 25;
        issue(24'h0A0B0C, 1'b1, 1'b1);
        issue(24'h111111, 1'b0, 1'b0);
        wait_idle("idle_overrun");
        chk("overrun_count", 32'(overrun_count), 1);

        // Timeout: engine ready never drops
        eng_stuck = 1'b1;
        issue(24'h222222, 1'b1, 1'b0);
        t0 = 0;
        while (busy === 1'b1 && t0 < 200) begin
            @(negedge clk);
            t0++;
        end
        chk("timeout_latency", 32'(cyc - last_pulse_cyc), 32'(TIMEOUT));
        chk("timeout_count", 32'(timeout_count), 1);
        eng_stuck = 1'b0;
        repeat (3) @(negedge clk);
        eng_hold = 2;
        issue(24'h333380, 1'b1, 1'b1);
        wait_idle("idle_after_timeout");

        // Reset while waiting for the engine
        eng_hold = 30;
        issue(24'h445566, 1'b1, 1'b0);
        chk("mid_busy", 32'(busy), 1);
        #3;
        reset = 1'b1;
        #1;
        chk_all_zero("midreset");
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        eng_hold = 2;
        issue(24'h5566FF, 1'b1, 1'b1);
        wait_idle("idle_after_reset");

        // Random-phase synchroniser run with echo engine
        p0 = n_pulse;
        t0 = n_tx;
        for (int i = 0; i < 100; i++) begin
            eng_hold = $urandom_range(1, 5);
            s = 24'($urandom);
            issue(s, 1'b1, 1'b1);
            wait_idle("idle_sync");
        end
        chk("sync_pulses", 32'(n_pulse - p0), 100);
        chk("sync_tx", 32'(n_tx - t0), 100);
        chk("final_overrun", 32'(overrun_count), 0);
        chk("final_timeout", 32'(timeout_count), 0);
        chk("exp_in_left", 32'(exp_in_q.size()), 0);
        chk("exp_tx_left", 32'(exp_tx_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
